// File: rtl/jk_word_loader_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | jk_pkg                                                           |
// | Shared state encoding and per-bit JK excitation for the loader.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package jk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  // Returns {J, K}; toggle (1,1) is never produced.
  function automatic logic [1:0] jk_excite_bit(input logic t, input logic q);
    logic [1:0] jk;
    jk = 2'b00;
    if (t && !q) begin
      jk = 2'b10;
    end else if (!t && q) begin
      jk = 2'b01;
    end
    return jk;
  endfunction

endpackage : jk_pkg
`default_nettype wire

// File: rtl/jk_word_loader_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | jk_word_loader_if                                                |
// | Word handshake plus JK bank drive/feedback bundle.               |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface jk_word_loader_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] q_fb;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             done;
  logic             error;

  // Environment side: offers words and returns the bank's Q.
  modport master (
    output in_valid, in_data, q_fb,
    input  in_ready, j, k, done, error
  );

  // Loader side.
  modport slave (
    input  in_valid, in_data, q_fb,
    output in_ready, j, k, done, error
  );
endinterface : jk_word_loader_if
`default_nettype wire

// File: rtl/jk_word_loader_excite.sv
`default_nettype none
// +------------------------------------------------------------------+
// | jk_excite                                                        |
// | Combinational per-bit J/K excitation from target and bank Q.     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module jk_excite
  import jk_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j_next,
  output logic [WIDTH-1:0] k_next
);

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic [1:0] w_jk;
      assign w_jk      = jk_excite_bit(target[i], q[i]);
      assign j_next[i] = w_jk[1];
      assign k_next[i] = w_jk[0];
    end
  endgenerate

endmodule : jk_excite
`default_nettype wire

// File: rtl/jk_word_loader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | jk_word_loader                                                   |
// | Loads a target word into a JK flip-flop bank with verify/retry.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module jk_word_loader
  import jk_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SETTLE    = 1,
  parameter int MAX_RETRY = 2
) (
  input  logic          clock,
  input  logic          clear,
  jk_word_loader_if.slave bus
);

  localparam int c_RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int c_SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [c_RW-1:0] c_MAX_RETRY   = c_RW'(MAX_RETRY);
  localparam logic [c_SW-1:0] c_SETTLE_LOAD = c_SW'(SETTLE - 1);

  state_t            r_state;
  logic [WIDTH-1:0]  r_target;
  logic [WIDTH-1:0]  r_j;
  logic [WIDTH-1:0]  r_k;
  logic [c_SW-1:0]   r_cnt;
  logic [c_RW-1:0]   r_retry;
  logic              r_done;
  logic              r_error;

  state_t            w_state;
  logic [WIDTH-1:0]  w_target;
  logic [WIDTH-1:0]  w_j;
  logic [WIDTH-1:0]  w_k;
  logic [c_SW-1:0]   w_cnt;
  logic [c_RW-1:0]   w_retry;
  logic              w_done;
  logic              w_error;

  logic [WIDTH-1:0]  w_exc_target;
  logic [WIDTH-1:0]  w_exc_j;
  logic [WIDTH-1:0]  w_exc_k;

  // At accept the target is not registered yet, so excite straight from in_data.
  assign w_exc_target = (r_state == ST_IDLE) ? bus.in_data : r_target;

  jk_excite #(
    .WIDTH (WIDTH)
  ) u_excite (
    .target (w_exc_target),
    .q      (bus.q_fb),
    .j_next (w_exc_j),
    .k_next (w_exc_k)
  );

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state  <= ST_IDLE;
      r_target <= '0;
      r_j      <= '0;
      r_k      <= '0;
      r_cnt    <= '0;
      r_retry  <= '0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_target <= w_target;
      r_j      <= w_j;
      r_k      <= w_k;
      r_cnt    <= w_cnt;
      r_retry  <= w_retry;
      r_done   <= w_done;
      r_error  <= w_error;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_target = r_target;
    w_j      = '0;
    w_k      = '0;
    w_cnt    = r_cnt;
    w_retry  = r_retry;
    w_done   = 1'b0;
    w_error  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.in_valid) begin
          w_target = bus.in_data;
          w_j      = w_exc_j;
          w_k      = w_exc_k;
          w_retry  = '0;
          w_state  = ST_DRIVE;
        end
      end

      ST_DRIVE: begin
        w_cnt   = c_SETTLE_LOAD;
        w_state = ST_SETTLE;
      end

      ST_SETTLE: begin
        if (r_cnt != '0) begin
          w_cnt = r_cnt - c_SW'(1);
        end else if (bus.q_fb == r_target) begin
          w_done  = 1'b1;
          w_state = ST_IDLE;
        end else if (r_retry < c_MAX_RETRY) begin
          w_retry = r_retry + c_RW'(1);
          w_j     = w_exc_j;
          w_k     = w_exc_k;
          w_state = ST_DRIVE;
        end else begin
          w_error = 1'b1;
          w_state = ST_IDLE;
        end
      end

      default: begin
        w_state = ST_IDLE;
      end
    endcase
  end

  assign bus.in_ready = (r_state == ST_IDLE);
  assign bus.j        = r_j;
  assign bus.k        = r_k;
  assign bus.done     = r_done;
  assign bus.error    = r_error;

endmodule : jk_word_loader
`default_nettype wire

// File: tb/tb_jk_word_loader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_jk_word_loader                                                |
// | Directed + random loads against a behavioural JK bank model.     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_jk_word_loader;

  localparam int W   = 8;
  localparam int SET = 1;
  localparam int MR  = 2;
  localparam int M_NORMAL = 0;
  localparam int M_IGNORE = 1;
  localparam int M_STUCK  = 2;

  logic clk;
  logic clear;

  jk_word_loader_if #(.WIDTH(W)) bus();

  jk_word_loader #(
    .WIDTH     (W),
    .SETTLE    (SET),
    .MAX_RETRY (MR)
  ) dut (
    .clock (clk),
    .clear (clear),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [W-1:0] bank_m;
  logic [W-1:0] bank_q;
  logic [W-1:0] force_val;
  logic         force_en;
  int           mode;
  int           txn_id;
  int           ign_id = 0;

  // Master-slave JK bank: master captures on rise, slave follows on fall.
  always @(posedge clk) begin
    if (force_en)
      bank_m <= force_val;
    else if (mode == M_STUCK)
      bank_m <= bank_m;
    else if (mode == M_IGNORE && ign_id != txn_id && (bus.j | bus.k) != '0)
      ign_id <= txn_id;
    else
      bank_m <= (bus.j & ~bank_m) | (~bus.k & bank_m);
  end

  always @(negedge clk) bank_q <= bank_m;

  assign bus.q_fb = bank_q;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic preset(input logic [W-1:0] v, input int m);
    @(negedge clk);
    force_en  = 1'b1;
    force_val = v;
    mode      = m;
    @(negedge clk);
    force_en  = 1'b0;
    #1;
  endtask

  task automatic load(input logic [W-1:0] word, input bit hold);
    logic [W-1:0] q0, ej, ek, eq;
    int att, edr, lat, drives, c;
    bit exp_err, seen;

    @(negedge clk);
    c = 0;
    while (!bus.in_ready && c < 20) begin
      @(negedge clk);
      c++;
    end
    check("ready_before_load", bus.in_ready, 1);

    txn_id++;
    bus.in_valid = 1'b1;
    bus.in_data  = word;
    @(posedge clk);
    q0 = bank_q;
    #1;

    ej = word & ~q0;
    ek = ~word & q0;
    exp_err = 1'b0;
    if (word == q0) begin
      att = 1; edr = 0; eq = q0;
    end else if (mode == M_NORMAL) begin
      att = 1; edr = 1; eq = word;
    end else if (mode == M_IGNORE) begin
      att = 2; edr = 2; eq = word;
    end else begin
      att = 1 + MR; edr = 1 + MR; eq = q0; exp_err = 1'b1;
    end
    lat = att * (1 + SET);

    check("accept_j", bus.j, ej);
    check("accept_k", bus.k, ek);

    if (hold) bus.in_data = ~word;
    else      bus.in_valid = 1'b0;

    drives = ((bus.j | bus.k) != '0) ? 1 : 0;
    seen = 1'b0;
    c = 0;
    while (!seen && c < 40) begin
      @(posedge clk);
      #1;
      c++;
      if ((bus.j | bus.k) != '0) drives++;
      check("no_toggle", bus.j & bus.k, 0);
      if (bus.done || bus.error) seen = 1'b1;
    end
    bus.in_valid = 1'b0;

    check("completed", seen, 1);
    check("latency", c, lat);
    check("done", bus.done, !exp_err);
    check("error", bus.error, exp_err);
    check("drives", drives, edr);
    check("ready_at_end", bus.in_ready, 1);
    check("bank_q", bank_q, eq);

    @(posedge clk);
    #1;
    check("pulse_len", {bus.done, bus.error}, 0);
  endtask

  initial begin
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    mode         = M_NORMAL;
    txn_id       = 0;
    force_en     = 1'b1;
    force_val    = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", bus.in_ready, 1);
    check("rst_j", bus.j, 0);
    check("rst_k", bus.k, 0);
    check("rst_done", bus.done, 0);
    check("rst_error", bus.error, 0);
    @(negedge clk);
    clear    = 1'b1;
    force_en = 1'b0;

    // Nominal load onto a cleared bank.
    preset(8'h00, M_NORMAL);
    load(8'hA5, 1'b0);

    // Clearing bits, then a reload of the same word (no excitation).
    preset(8'hFF, M_NORMAL);
    load(8'h0F, 1'b0);
    load(8'h0F, 1'b0);

    // Bank misses the first drive: one retry.
    preset(8'h0F, M_IGNORE);
    load(8'hF0, 1'b0);

    // Bank stuck: retries exhausted.
    preset(8'h00, M_STUCK);
    load(8'h01, 1'b0);

    // in_valid held with different data while busy.
    preset(8'h11, M_NORMAL);
    load(8'h96, 1'b1);

    // Asynchronous clear during DRIVE.
    preset(8'h3C, M_NORMAL);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hC3;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("abort_drive_j", bus.j, 8'hC3);
    #2;
    clear = 1'b0;
    #1;
    check("abort_j", bus.j, 0);
    check("abort_k", bus.k, 0);
    check("abort_ready", bus.in_ready, 1);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("abort_pulses", {bus.done, bus.error}, 0);
    end
    @(negedge clk);
    clear = 1'b1;
    check("abort_bank", bank_q, 8'h3C);

    // Randomized loads.
    for (int n = 0; n < 24; n++) begin
      logic [W-1:0] w;
      if ($urandom_range(0, 2) == 0 || mode == M_STUCK)
        preset(W'($urandom), int'($urandom_range(0, 2)));
      w = W'($urandom);
      if ($urandom_range(0, 4) == 0) w = bank_q;
      load(w, bit'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_jk_word_loader
`default_nettype wire

// File: doc/jk_word_loader.md
# jk_word_loader

Sequential driver for a bank of WIDTH master-slave JK flip-flops that must be loaded with a target word. Accepts a word over a valid/ready handshake, derives per-bit J/K excitation from the target and the bank's fed-back Q, then pulses J/K for one clock. After a settle interval it checks Q against the target, retries on mismatch, and reports done or error. It is the input-side companion to the master-slave JK register: it writes the bank, and the bank only stores.

## Interface
- WIDTH, 8: number of JK flip-flops driven.
- SETTLE, 1: cycles with J=K=0 before Q is compared. Must be ≥1.
- MAX_RETRY, 2: extra drive attempts allowed after the first mismatch.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- clear  in  1  reset, asynchronous, active-low.
- in_valid  in  1  target word offered.
- in_ready  out  1  high only in IDLE.
- in_data  in  WIDTH  target word.
- q_fb  in  WIDTH  Q outputs of the JK bank.
- j  out  WIDTH  J drive to the bank, registered.
- k  out  WIDTH  K drive to the bank, registered.
- done  out  1  one-cycle pulse: bank verified equal to the target.
- error  out  1  one-cycle pulse: retries exhausted with a mismatch.

## Operation
- States: IDLE, DRIVE, SETTLE, CHECK is folded into the last SETTLE edge.
- Excitation per bit, from target t and q_fb q:
  - t=1, q=0 gives J=1, K=0.
  - t=0, q=1 gives J=0, K=1.
  - t==q gives J=0, K=0.
  - J=K=1 (toggle) is never issued.
- IDLE:
  - in_ready=1, j=k=0.
  - On in_valid && in_ready, the block registers in_data as the target, loads j/k from in_data and q_fb sampled at the same edge, clears the retry count, and moves to DRIVE.
- DRIVE:
  - Lasts exactly one cycle with j/k held.
  - The next edge sets j=k=0, loads the settle counter with SETTLE-1, and moves to SETTLE.
- SETTLE:
  - Counts down. At the edge where the counter is 0, q_fb is compared with the target.
  - Match: done=1 for one cycle, go to IDLE.
  - Mismatch and retry<MAX_RETRY: retry+1, recompute j/k from the current q_fb, go to DRIVE.
  - Mismatch and retry==MAX_RETRY: error=1 for one cycle, go to IDLE.
- If the target already equals q_fb at accept, the full DRIVE/SETTLE sequence still runs with j=k=0, then done.
- in_valid outside IDLE is ignored. The held target is never overwritten mid-operation.
- Retry counter width is $clog2(MAX_RETRY+1), minimum 1 bit.

## Timing
- Reset values (clear=0, asynchronous):
  - state=IDLE, in_ready=1, j=0, k=0, done=0, error=0.
  - Target register, settle counter and retry counter are all 0.
- Reset asserted mid-operation forces j=k=0 immediately, without waiting for a clock edge. No done or error pulse is produced for the aborted word.
- Latency for SETTLE=1 with no retry:
  - Accept at edge N; DRIVE runs in cycle N..N+1.
  - Compare at edge N+2; done is high from N+2 to N+3.
  - in_ready rises at N+2, so the next word can be accepted at edge N+3.
- Each retry adds 1+SETTLE cycles.
- done and error are never high together, and each lasts exactly one cycle.
- in_ready is combinational from state, so it is high in the same cycle the block returns to IDLE.
- The bank's master captures at the rising edge that ends DRIVE, and its slave updates at the following falling edge. With SETTLE ≥1, q_fb is stable before the compare edge.

## Structure
- Package jk_pkg contains:
  - The state enum (IDLE, DRIVE, SETTLE).
  - The per-bit excitation function (t, q) → {J, K}.
- Sub-module jk_excite is combinational. It maps WIDTH-bit target and q to WIDTH-bit j_next and k_next, and is instantiated once.
- Top level holds the FSM, the counters and the output registers.

## Test plan
- Reset, then load 8'hA5 into a bank at 8'h00: at accept, j=8'hA5, k=8'h00. done pulses at edge N+2, and q_fb=8'hA5.
- Bank at 8'hFF, load 8'h0F: j=8'h00, k=8'hF0, then done. A second load of 8'h0F drives j=k=0 and still produces done after 2 cycles.
- A model that ignores the first drive with MAX_RETRY=2: j/k are reissued once and done arrives 2 cycles later than in the nominal case.
- Bank stuck at 8'h00, load 8'h01, MAX_RETRY=2: 3 DRIVE cycles, then error pulses for 1 cycle and done never rises.
- in_valid held high during DRIVE/SETTLE with different data: ignored, and the original target completes.
- clear pulled low during DRIVE: j=k=0 with no clock edge, state returns to IDLE with in_ready=1, and neither done nor error pulses.
